hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS32 core.
- Produces the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers: IF_stall, ID_stall, ID_flush and EX_stall.
- Detects load-use hazards, sequences multi-cycle MUL/DIV occupancy of EX, and handles flush requests (exception/ERET) raised from EX.
- Sits beside the decoder; its outputs drive the pipeline-register hold/bubble inputs in the same cycle.

Parameters:
- MUL_LATENCY, 4: total EX cycles for MULT/MULTU, range 2..63.
- DIV_LATENCY, 33: total EX cycles for DIV/DIVU, range 2..63.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_rs_read  in  1  ID instruction reads rs
- ID_rt_read  in  1  ID instruction reads rt
- EX_reg_dst  in  5  destination register of instruction in EX
- EX_memread  in  1  EX instruction is a load
- EX_regwrite  in  1  EX instruction writes a GPR
- EX_md_start  in  1  MUL/DIV instruction present in EX (level, first EX cycle)
- EX_md_div  in  1  1 = divide, 0 = multiply; valid with EX_md_start
- EX_flush_req  in  1  exception/ERET taken in EX; kill younger instructions
- IF_stall  out  1  hold PC and IF/ID register
- ID_stall  out  1  insert bubble into ID/EX (zero controls)
- ID_flush  out  1  squash instruction entering ID/EX
- EX_stall  out  1  hold ID/EX register contents
- md_busy  out  1  MUL/DIV sequencer active
- md_done  out  1  one-cycle pulse on last MUL/DIV cycle

Behaviour:
- States: IDLE, MD_BUSY. Registers: state, 6-bit down-counter cnt.
- Reset, while rst=1 at a posedge: state=IDLE, cnt=0. While rst=1, all outputs are forced to 0 combinationally.
- Outputs are combinational from state, cnt and the current inputs; there is no added latency.
- Load-use hazard, lu:
  - Requires EX_memread & EX_regwrite & (EX_reg_dst != 0).
  - And (ID_rs_read & ID_rs == EX_reg_dst) | (ID_rt_read & ID_rt == EX_reg_dst).
  - Register $0 never produces a hazard.
- Priority, highest first: flush > MD_BUSY > MD start > lu.
- Flush: EX_flush_req=1 in any state.
  - Outputs: ID_flush=1, IF_stall=0, ID_stall=0, EX_stall=0.
  - Next state IDLE, cnt=0. An in-progress MUL/DIV is abandoned and md_done is not asserted.
- IDLE, EX_md_start=1 with no flush:
  - cnt <= (EX_md_div ? DIV_LATENCY : MUL_LATENCY) - 2; state <= MD_BUSY.
  - Outputs this cycle: EX_stall=1, IF_stall=1, md_busy=1.
- MD_BUSY:
  - EX_stall=1, IF_stall=1, md_busy=1, ID_stall=0.
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: md_done=1, EX_stall=0, IF_stall=0, state <= IDLE.
  - Total EX occupancy is exactly the configured latency, counting the start cycle.
  - EX_md_start is ignored while in MD_BUSY.
- IDLE, lu=1 with no MD start and no flush:
  - IF_stall=1, ID_stall=1 for exactly that cycle.
  - The next cycle the load is in MEM, lu deasserts and forwarding resolves the value.
  - Back-to-back loads feeding each other produce one bubble per dependent pair.
- lu during MD_BUSY is masked, because EX_stall freezes EX. It is re-evaluated the cycle after md_done.
- Reset mid-operation returns to IDLE on the next edge; a pending MUL/DIV is lost.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_lu_cnt[31:0], perf_md_cnt[31:0] and perf_flush_cnt[31:0].
  - Each counts cycles with lu stall, EX_stall, and ID_flush asserted, respectively.
  - Counters are cleared by rst, are free-running, and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX_memread=1, EX_regwrite=1, EX_reg_dst=5, ID_rs=5, ID_rs_read=1 -> IF_stall=ID_stall=1 for 1 cycle; with EX_reg_dst=0 -> no stall.
- MUL: EX_md_start=1, EX_md_div=0, MUL_LATENCY=4 -> EX_stall high 3 cycles, then md_done=1 with EX_stall=0 in cycle 4; state returns to IDLE.
- DIV: EX_md_start=1, EX_md_div=1, DIV_LATENCY=33 -> EX_stall high 32 cycles; md_done in cycle 33; lu asserted mid-busy -> ID_stall stays 0.
- Flush abort: EX_flush_req=1 on busy cycle 10 of a DIV -> ID_flush=1, EX_stall=0 that cycle; md_done never pulses; next cycle md_busy=0.
- Simultaneous: EX_flush_req=1 with lu=1 -> ID_flush=1, ID_stall=0, IF_stall=0.
- Reset: rst=1 during MD_BUSY -> all outputs 0; after release, EX_md_start=0 -> md_busy=0; with HAZARD_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline: load-use bubbles, MUL/DIV EX occupancy, EX flushes.
// Outputs are combinational from state and inputs (zero latency); optional HAZARD_PERF_EN adds cycle counters.
module hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_rs_read,
    input  logic       ID_rt_read,
    input  logic [4:0] EX_reg_dst,
    input  logic       EX_memread,
    input  logic       EX_regwrite,
    input  logic       EX_md_start,
    input  logic       EX_md_div,
    input  logic       EX_flush_req,
    output logic       IF_stall,
    output logic       ID_stall,
    output logic       ID_flush,
    output logic       EX_stall,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_md_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic {IDLE, MD_BUSY} state_t;

    // Counter is loaded with latency-2: the start cycle and the done cycle are not counted down.
    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 2);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 2);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       lu;

    always_comb begin
        lu = EX_memread && EX_regwrite && (EX_reg_dst != 5'd0) &&
             ((ID_rs_read && (ID_rs == EX_reg_dst)) ||
              (ID_rt_read && (ID_rt == EX_reg_dst)));

        state_d  = state_q;
        cnt_d    = cnt_q;
        IF_stall = 1'b0;
        ID_stall = 1'b0;
        ID_flush = 1'b0;
        EX_stall = 1'b0;
        md_busy  = 1'b0;
        md_done  = 1'b0;

        if (rst) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else if (EX_flush_req) begin
            ID_flush = 1'b1;
            state_d  = IDLE;
            cnt_d    = 6'd0;
        end else if (state_q == MD_BUSY) begin
            md_busy = 1'b1;
            if (cnt_q == 6'd0) begin
                md_done = 1'b1;
                state_d = IDLE;
            end else begin
                EX_stall = 1'b1;
                IF_stall = 1'b1;
                cnt_d    = cnt_q - 6'd1;
            end
        end else if (EX_md_start) begin
            EX_stall = 1'b1;
            IF_stall = 1'b1;
            md_busy  = 1'b1;
            cnt_d    = EX_md_div ? DIV_CNT : MUL_CNT;
            state_d  = MD_BUSY;
        end else if (lu) begin
            IF_stall = 1'b1;
            ID_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_md_q, perf_md_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_lu_d    = perf_lu_q + {31'd0, ID_stall};
        perf_md_d    = perf_md_q + {31'd0, EX_stall};
        perf_flush_d = perf_flush_q + {31'd0, ID_flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q    <= 32'd0;
            perf_md_q    <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_lu_q    <= perf_lu_d;
            perf_md_q    <= perf_md_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_lu_cnt    = perf_lu_q;
    assign perf_md_cnt    = perf_md_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle occupancy model plus hand-computed expectations.
module tb_hazard_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_reg_dst;
    logic       ID_rs_read, ID_rt_read, EX_memread, EX_regwrite;
    logic       EX_md_start, EX_md_div, EX_flush_req;
    logic       IF_stall, ID_stall, ID_flush, EX_stall, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_md_cnt, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_read(ID_rs_read), .ID_rt_read(ID_rt_read),
        .EX_reg_dst(EX_reg_dst), .EX_memread(EX_memread), .EX_regwrite(EX_regwrite),
        .EX_md_start(EX_md_start), .EX_md_div(EX_md_div), .EX_flush_req(EX_flush_req),
        .IF_stall(IF_stall), .ID_stall(ID_stall), .ID_flush(ID_flush), .EX_stall(EX_stall),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
        , .perf_lu_cnt(perf_lu_cnt), .perf_md_cnt(perf_md_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: md_left = EX cycles still owed by the current MUL/DIV (0 = none in flight).
    int   md_left = 0, nxt_left = 0;
    logic e_if, e_id, e_fl, e_ex, e_busy, e_done;
    longint p_lu = 0, p_md = 0, p_fl = 0;

    always @(negedge clk) begin
        logic hz;
        hz = EX_memread && EX_regwrite && EX_reg_dst != 0 &&
             ((ID_rs_read && ID_rs == EX_reg_dst) || (ID_rt_read && ID_rt == EX_reg_dst));
        {e_if, e_id, e_fl, e_ex, e_busy, e_done} = '0;
        nxt_left = md_left;
        if (rst) begin
            nxt_left = 0;
        end else if (EX_flush_req) begin
            e_fl = 1; nxt_left = 0;
        end else if (md_left > 0) begin
            e_busy = 1;
            if (md_left == 1) e_done = 1;
            else begin e_ex = 1; e_if = 1; end
            nxt_left = md_left - 1;
        end else if (EX_md_start) begin
            e_ex = 1; e_if = 1; e_busy = 1;
            nxt_left = (EX_md_div ? DIV_LAT : MUL_LAT) - 1;
        end else if (hz) begin
            e_if = 1; e_id = 1;
        end
        chk("IF_stall", IF_stall, e_if);
        chk("ID_stall", ID_stall, e_id);
        chk("ID_flush", ID_flush, e_fl);
        chk("EX_stall", EX_stall, e_ex);
        chk("md_busy",  md_busy,  e_busy);
        chk("md_done",  md_done,  e_done);
`ifdef HAZARD_PERF_EN
        chk("perf_lu",    perf_lu_cnt,    p_lu);
        chk("perf_md",    perf_md_cnt,    p_md);
        chk("perf_flush", perf_flush_cnt, p_fl);
`endif
    end

    always @(posedge clk) begin
        md_left = nxt_left;
        if (rst) begin
            p_lu = 0; p_md = 0; p_fl = 0;
        end else begin
            p_lu = (p_lu + e_id) & 64'hFFFF_FFFF;
            p_md = (p_md + e_ex) & 64'hFFFF_FFFF;
            p_fl = (p_fl + e_fl) & 64'hFFFF_FFFF;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic on);
        EX_memread  = on;
        EX_regwrite = on;
        EX_reg_dst  = on ? 5'd5 : 5'd0;
        ID_rs       = on ? 5'd5 : 5'd0;
        ID_rs_read  = on;
    endtask

    // Issue one MUL/DIV and observe a fixed 40-cycle window.
    task automatic md_run(input logic div, input int flush_at, input logic lu_mid,
                          output int stalls, output int dones);
        stalls = 0;
        dones  = 0;
        EX_md_start = 1'b1;
        EX_md_div   = div;
        for (int c = 1; c <= 40; c++) begin
            if (c == flush_at) EX_flush_req = 1'b1;
            if (lu_mid && c == 5) set_lu(1'b1);
            @(negedge clk);
            if (EX_stall) stalls++;
            if (md_done) dones++;
            if (c == flush_at) begin
                chk("abort_ID_flush", ID_flush, 1);
                chk("abort_EX_stall", EX_stall, 0);
            end
            if (flush_at > 0 && c == flush_at + 1) chk("abort_next_busy", md_busy, 0);
            if (lu_mid && c == 5) begin
                chk("lu_masked_ID_stall", ID_stall, 0);
                chk("lu_masked_busy", md_busy, 1);
            end
            step();
            EX_md_start  = 1'b0;
            EX_flush_req = 1'b0;
            if (lu_mid && c == 5) set_lu(1'b0);
        end
    endtask

    initial begin
        int stalls, dones;
        rst = 1'b1;
        ID_rs = 0; ID_rt = 0; ID_rs_read = 0; ID_rt_read = 0;
        EX_reg_dst = 0; EX_memread = 0; EX_regwrite = 0;
        EX_md_start = 0; EX_md_div = 0; EX_flush_req = 0;
        step(); step();
        @(negedge clk);
        chk("reset_IF_stall", IF_stall, 0);
        chk("reset_md_busy", md_busy, 0);
        step();
        rst = 1'b0;
        step();

        // Load-use on rs, then load moves on to MEM.
        set_lu(1'b1);
        @(negedge clk);
        chk("lu_IF_stall", IF_stall, 1);
        chk("lu_ID_stall", ID_stall, 1);
        step();
        EX_memread = 1'b0;
        @(negedge clk);
        chk("lu_released", ID_stall, 0);
        step();
        // $0 destination never stalls.
        set_lu(1'b1);
        EX_reg_dst = 5'd0; ID_rs = 5'd0;
        @(negedge clk);
        chk("lu_r0", ID_stall, 0);
        step();
        // rt match counts only when rt is read.
        set_lu(1'b1);
        ID_rs_read = 0; ID_rs = 5'd7; ID_rt = 5'd5; ID_rt_read = 0;
        @(negedge clk);
        chk("lu_rt_unread", ID_stall, 0);
        step();
        ID_rt_read = 1'b1;
        @(negedge clk);
        chk("lu_rt_read", ID_stall, 1);
        step();
        set_lu(1'b0); ID_rt = 0; ID_rt_read = 0;
        step();

        md_run(1'b0, 0, 1'b0, stalls, dones);
        chk("mul_stall_cycles", stalls, 3);
        chk("mul_done_pulses", dones, 1);

        md_run(1'b1, 0, 1'b1, stalls, dones);
        chk("div_stall_cycles", stalls, 32);
        chk("div_done_pulses", dones, 1);

        md_run(1'b1, 10, 1'b0, stalls, dones);
        chk("abort_stall_cycles", stalls, 9);
        chk("abort_done_pulses", dones, 0);

        // Flush wins over load-use.
        set_lu(1'b1);
        EX_flush_req = 1'b1;
        @(negedge clk);
        chk("sim_ID_flush", ID_flush, 1);
        chk("sim_ID_stall", ID_stall, 0);
        chk("sim_IF_stall", IF_stall, 0);
        step();
        EX_flush_req = 1'b0;
        set_lu(1'b0);
        step();

        // Reset in the middle of a DIV.
        EX_md_start = 1'b1; EX_md_div = 1'b1;
        step();
        EX_md_start = 1'b0;
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_EX_stall", EX_stall, 0);
        chk("rst_mid_md_busy", md_busy, 0);
        step();
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        chk("perf_lu_cleared", perf_lu_cnt, 0);
        chk("perf_md_cleared", perf_md_cnt, 0);
        step();
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_md_busy", md_busy, 0);
        chk("post_rst_EX_stall", EX_stall, 0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
